multdiv: RTL and testbench

- Multi-cycle signed integer multiply/divide unit for the processor execute stage.
- Computes a 32-bit signed operand A times or divided by a 16-bit signed operand B.
- Returns a 32-bit signed result with an exception flag.
- Uses a request/ready handshake: inputRDY before operands are taken, resultRDY when the result is valid.

---
 rtl/multdiv_pkg.sv | 57 +++++
 rtl/multdiv_divider.sv | 51 +++++
 rtl/multdiv.sv | 129 ++++++++++++
 tb/tb_multdiv.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types, constants and arithmetic helpers for the multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {IDLE, MBUSY, DBUSY, DONE} state_t;

    localparam int          MULT_LAT     = 2;
    localparam int          DIV_ITER     = 16;
    localparam int          PP_PER_CYCLE = 4;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    typedef struct packed {
        logic [15:0] rem;
        logic [31:0] quo;
    } div_state_t;

    // Sum of the radix-4 Booth partial products belonging to one multiply cycle.
    function automatic logic signed [47:0] booth_group(input logic [31:0] a,
                                                       input logic [15:0] b,
                                                       input int          grp);
        logic [16:0]        b_ext;
        logic signed [47:0] a_ext;
        logic signed [47:0] pp;
        logic signed [47:0] sum;
        int                 j;
        b_ext = {b, 1'b0};
        a_ext = {{16{a[31]}}, a};
        sum   = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            j = grp * PP_PER_CYCLE + k;
            case (b_ext[2*j +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            sum = sum + (pp <<< (2 * j));
        end
        return sum;
    endfunction

    // One restoring-division step on magnitudes: shift in a dividend bit, trial subtract.
    function automatic div_state_t div_step(input div_state_t s, input logic [15:0] dvs);
        logic [16:0] trial;
        div_state_t  n;
        trial = {s.rem, s.quo[31]};
        n.quo = {s.quo[30:0], 1'b0};
        n.rem = trial[15:0];
        if (trial >= {1'b0, dvs}) begin
            trial    = trial - {1'b0, dvs};
            n.rem    = trial[15:0];
            n.quo[0] = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/multdiv_divider.sv
// Unsigned 32/16 restoring divider, two quotient bits per cycle; o_done holds until next start.
module multdiv_divider
    import multdiv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic        o_done
);

    localparam int CNT_W = $clog2(DIV_ITER);

    div_state_t       r_st;
    logic [15:0]      r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    div_state_t       w_next;

    assign w_next     = div_step(div_step(r_st, r_dvs), r_dvs);
    assign o_quotient = r_st.quo;
    assign o_done     = r_done;

    // NOTE: reset is synchronous (sampled only on the clock edge) and all state uses <=.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st   <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_st   <= '{rem: 16'd0, quo: i_dividend};
            r_dvs  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_st  <= w_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multdiv.sv
// Multi-cycle signed 32x16 multiply / 32/16 divide with edge-triggered request handshake.
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] data_operandA,
    input  logic [15:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_inputRDY,
    output logic        data_resultRDY
);

    localparam int MCNT_W = $clog2(MULT_LAT);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_mult_q, r_div_q;
    logic [31:0]         r_a;
    logic [15:0]         r_b;
    logic signed [47:0]  r_acc;
    logic [MCNT_W-1:0]   r_mcnt;
    logic                r_dz;
    logic [31:0]         r_result;
    logic                r_exc;
    logic                r_rdy;

    logic                w_start_m, w_start_d, w_mult_last, w_neg;
    logic signed [47:0]  w_prod;
    logic                w_mult_ovf, w_div_ovf, w_div_done;
    logic [31:0]         w_a_mag, w_quo, w_div_res;
    logic [15:0]         w_b_mag;

    assign data_inputRDY  = (r_state == IDLE) || (r_state == DONE);
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

    assign w_start_m = ctrl_MULT & ~r_mult_q & data_inputRDY;
    assign w_start_d = ctrl_DIV & ~r_div_q & data_inputRDY & ~w_start_m;

    assign w_prod      = r_acc + booth_group(r_a, r_b, int'(r_mcnt));
    assign w_mult_last = (r_mcnt == MCNT_W'(MULT_LAT - 1));
    assign w_mult_ovf  = !((&w_prod[47:31]) || !(|w_prod[47:31]));
    assign w_neg       = r_a[31] ^ r_b[15];

    assign w_a_mag   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign w_b_mag   = data_operandB[15] ? (~data_operandB + 16'd1) : data_operandB;
    assign w_div_res = w_neg ? (~w_quo + 32'd1) : w_quo;
    assign w_div_ovf = (r_a == INT_MIN) && (r_b == 16'hFFFF);

    multdiv_divider u_divider (
        .i_clk      (clock),
        .i_rst      (ctrl_reset),
        .i_start    (w_start_d && (data_operandB != 16'd0)),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quotient (w_quo),
        .o_done     (w_div_done)
    );

    always_ff @(posedge clock) begin
        if (ctrl_reset) r_state <= IDLE;
        else            r_state <= w_next_state;
    end

    // NOTE: next-state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_m)      w_next_state = MBUSY;
                else if (w_start_d) w_next_state = DBUSY;
            end
            MBUSY:   if (w_mult_last) w_next_state = DONE;
            DBUSY:   if (r_dz || w_div_done) w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_mult_q <= 1'b0;
            r_div_q  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mcnt   <= '0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_mult_q <= ctrl_MULT;
            r_div_q  <= ctrl_DIV;
            if (w_start_m || w_start_d) begin
                r_a    <= data_operandA;
                r_b    <= data_operandB;
                r_acc  <= '0;
                r_mcnt <= '0;
                r_dz   <= w_start_d && (data_operandB == 16'd0);
                r_rdy  <= 1'b0;
            end else if (r_state == MBUSY) begin
                r_acc  <= w_prod;
                r_mcnt <= r_mcnt + 1'b1;
                if (w_mult_last) begin
                    r_result <= w_prod[31:0];
                    r_exc    <= w_mult_ovf || (w_prod[31] != w_neg);
                    r_rdy    <= 1'b1;
                end
            end else if (r_state == DBUSY) begin
                // Divide-by-zero skips the iterations entirely.
                if (r_dz) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                    r_rdy    <= 1'b1;
                end else if (w_div_done) begin
                    r_result <= w_div_res;
                    r_exc    <= w_div_ovf || (w_div_res[31] != w_neg);
                    r_rdy    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed corner cases plus randomized ops against an arithmetic model.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [31:0] data_operandA;
    logic [15:0] data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_inputRDY, data_resultRDY;

    int n_tests = 0;
    int n_fail  = 0;

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    always #5 clock = ~clock;

    multdiv dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic in 64 bits, then truncate to 32.
    function automatic void model(input bit is_mult, input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] res, output logic exc, output int lat);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_mult && sb == 0) begin
            res = 32'd0;
            exc = 1'b1;
            lat = 1;
            return;
        end
        r   = is_mult ? sa * sb : sa / sb;
        lat = is_mult ? 2 : 17;
        res = r[31:0];
        exc = (r > MAX32) || (r < MIN32) || (res[31] != ((sa < 0) ^ (sb < 0)));
    endfunction

    task automatic drive(input bit m, input bit d, input logic [31:0] a, input logic [15:0] b);
        @(posedge clock);
        #1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        check("idle_inputRDY", 32'(data_inputRDY), 32'd1);
    endtask

    task automatic release_req();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Waits through the start edge, scrambles operands, then counts edges until resultRDY.
    task automatic wait_check(input bit is_mult, input logic [31:0] a, input logic [15:0] b,
                              input string tag);
        logic [31:0] e_res;
        logic        e_exc;
        int          e_lat;
        int          n;
        model(is_mult, a, b, e_res, e_exc, e_lat);
        @(posedge clock);
        #1;
        check({tag, ":busy_inputRDY"}, 32'(data_inputRDY), 32'd0);
        check({tag, ":busy_resultRDY"}, 32'(data_resultRDY), 32'd0);
        data_operandA = $urandom;
        data_operandB = 16'($urandom);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 40);
        check({tag, ":latency"}, 32'(n), 32'(e_lat));
        check({tag, ":result"}, data_result, e_res);
        check({tag, ":exception"}, 32'(data_exception), 32'(e_exc));
        check({tag, ":done_inputRDY"}, 32'(data_inputRDY), 32'd1);
    endtask

    task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [15:0] b,
                          input string tag);
        drive(is_mult, !is_mult, a, b);
        wait_check(is_mult, a, b, tag);
        release_req();
    endtask

    logic [15:0] b_pool [6] = '{16'd0, 16'd1, 16'hFFFF, 16'd7, 16'h8000, 16'h7FFF};
    logic [31:0] a_pool [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF};

    initial begin
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_resultRDY", 32'(data_resultRDY), 32'd0);
        check("rst_inputRDY", 32'(data_inputRDY), 32'd1);
        check("rst_result", data_result, 32'd0);
        check("rst_exception", 32'(data_exception), 32'd0);
        ctrl_reset = 1'b0;

        run_op(1'b1, 32'd7, -16'sd3, "m7x-3");
        check("m7x-3_const", data_result, 32'hFFFF_FFEB);
        run_op(1'b1, 32'h4000_0000, 16'd4, "m_ovf");
        run_op(1'b1, 32'd0, -16'sd3, "m0x-3");
        run_op(1'b0, -32'sd100, 16'd7, "d-100/7");
        check("d-100/7_const", data_result, 32'hFFFF_FFF2);
        run_op(1'b0, -32'sd5, 16'd7, "d-5/7");
        run_op(1'b0, 32'h8000_0000, 16'hFFFF, "d_ovf");
        run_op(1'b0, 32'd12345, 16'd0, "d_by0");

        // Request held past completion must not restart; a DIV edge in the same cycle MULT drops is taken.
        drive(1'b1, 1'b0, 32'd7, -16'sd3);
        wait_check(1'b1, 32'd7, -16'sd3, "hold");
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("hold_resultRDY", 32'(data_resultRDY), 32'd1);
            check("hold_result", data_result, 32'hFFFF_FFEB);
        end
        data_operandA = -32'sd100;
        data_operandB = 16'd7;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b1;
        wait_check(1'b0, -32'sd100, 16'd7, "swap_div");
        release_req();

        drive(1'b1, 1'b1, 32'd1000, -16'sd9);
        wait_check(1'b1, 32'd1000, -16'sd9, "both_mult");
        release_req();

        // Reset in the middle of a divide.
        drive(1'b0, 1'b1, -32'sd100, 16'd7);
        repeat (5) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        ctrl_DIV   = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_resultRDY", 32'(data_resultRDY), 32'd0);
        check("midrst_inputRDY", 32'(data_inputRDY), 32'd1);
        check("midrst_result", data_result, 32'd0);
        check("midrst_exception", 32'(data_exception), 32'd0);
        ctrl_reset = 1'b0;
        run_op(1'b1, 32'd6, 16'd7, "m6x7");
        check("m6x7_const", data_result, 32'd42);

        for (int i = 0; i < 40; i++) begin
            logic        op;
            logic [31:0] a;
            logic [15:0] b;
            op = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 4) == 0) ? a_pool[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = b_pool[$urandom_range(0, 5)];
                1:       b = 16'($urandom_range(0, 20)) - 16'd10;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) a = 32'($signed(a) >>> $urandom_range(0, 31));
            run_op(op, a, b, op ? "rand_mult" : "rand_div");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
